mp_alu_seq: RTL and testbench

- Multi-precision sequencer that drives the datapath ALU from the control side.
- Executes ADD, SUB, AND, OR, NOT and MVC over operands of up to 2^ADDR_W words, stored least-significant word first in two operand banks.
- Propagates carry/borrow between words through a second ALU pass, because the ALU has no carry-in.
- Writes each result word back through a write port and reports the final carry.

---
 rtl/mp_alu_seq.sv | 160 ++++++++++++++++
 tb/tb_mp_alu_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: walks operand words through an external ALU, LS word first,
// and folds carry/borrow into the next word with a second ALU pass.
`ifndef WIDTH_WORD
`define WIDTH_WORD 8
`endif

module mp_alu_seq #(
  parameter int unsigned WIDTH  = `WIDTH_WORD,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              carry_out,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_a_data,
  input  logic [WIDTH-1:0]  rd_b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [2:0]        alu_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_y,
  input  logic              alu_carry
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMvc = 3'b101;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StExec  = 3'd2;
  localparam logic [2:0] StFix   = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [ADDR_W:0]   LenOne = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IdxOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  WordOne = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              cin_q, cin_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              c_q, c_d;
  logic              carry_q, carry_d;

  logic is_arith;
  logic last_word;

  assign is_arith  = (op_q == OpAdd) || (op_q == OpSub);
  assign last_word = ({1'b0, idx_q} == (len_q - LenOne));

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign wr_en     = (state_q == StWrite);
  assign rd_addr   = idx_q;
  assign wr_addr   = idx_q;
  assign wr_data   = y_q;
  assign carry_out = carry_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    y_d     = y_q;
    c_d     = c_q;
    carry_d = carry_q;
    alu_op  = OpMvc;
    alu_a   = '0;
    alu_b   = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          len_d   = len;
          idx_d   = '0;
          cin_d   = 1'b0;
          carry_d = 1'b0;
          // Zero length and the two undefined opcodes complete without touching the banks.
          if ((len == '0) || (op[2:1] == 2'b11)) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end

      StFetch: state_d = StExec;

      StExec: begin
        alu_op  = op_q;
        alu_a   = rd_a_data;
        alu_b   = rd_b_data;
        y_d     = alu_y;
        c_d     = is_arith & alu_carry;
        state_d = (is_arith && cin_q) ? StFix : StWrite;
      end

      // Apply the incoming carry/borrow as +/-1; at most one of the two passes can carry.
      StFix: begin
        alu_op  = op_q;
        alu_a   = y_q;
        alu_b   = WordOne;
        y_d     = alu_y;
        c_d     = c_q | alu_carry;
        state_d = StWrite;
      end

      StWrite: begin
        cin_d = c_q;
        if (last_word) begin
          carry_d = c_q;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxOne;
          state_d = StFetch;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      y_q     <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      y_q     <= y_d;
      c_q     <= c_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Scoreboard bench for mp_alu_seq with a behavioural ALU and registered operand banks.
module tb_mp_alu_seq;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    op;
  logic [AW:0]   len;
  logic          busy, done, carry_out, wr_en, alu_carry;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  rd_a_data, rd_b_data, wr_data, alu_a, alu_b, alu_y;
  logic [2:0]    alu_op;

  always #5 clk = ~clk;

  mp_alu_seq #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .len(len),
    .busy(busy), .done(done), .carry_out(carry_out),
    .rd_addr(rd_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_carry(alu_carry)
  );

  logic [W-1:0] mem_a [16];
  logic [W-1:0] mem_b [16];

  always @(posedge clk) begin
    rd_a_data <= mem_a[rd_addr];
    rd_b_data <= mem_b[rd_addr];
  end

  always_comb begin
    alu_y     = '0;
    alu_carry = 1'b0;
    case (alu_op)
      3'b000:  {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  {alu_carry, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = ~alu_a;
      3'b101:  alu_y = alu_a;
      default: alu_y = '0;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  logic [11:0] exp_wr_q[$];
  logic        exp_c_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      n_writes++;
      if (exp_wr_q.size() == 0) begin
        check("wr_unexpected", 32'(exp_wr_q.size()), 1);
      end else begin
        logic [11:0] e;
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[11:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
    if (done) begin
      if (exp_c_q.size() == 0) begin
        check("done_unexpected", 32'(exp_c_q.size()), 1);
      end else begin
        logic ec;
        ec = exp_c_q.pop_front();
        check("carry_out", 32'(carry_out), 32'(ec));
      end
    end
  end

  // Reference: straightforward multi-word arithmetic with an explicit carry chain.
  task automatic model(input logic [2:0] o, input int l, output int cycles, output logic c);
    logic [8:0] s;
    logic [3:0] ia;
    c = 1'b0;
    cycles = 1;
    if (l == 0 || o >= 3'd6) begin
      exp_c_q.push_back(1'b0);
      return;
    end
    for (int i = 0; i < l; i++) begin
      s = '0;
      case (o)
        3'd0: begin
          cycles += c ? 4 : 3;
          s = {1'b0, mem_a[i]} + {1'b0, mem_b[i]} + {8'b0, c};
          c = s[8];
        end
        3'd1: begin
          cycles += c ? 4 : 3;
          s = {1'b0, mem_a[i]} - {1'b0, mem_b[i]} - {8'b0, c};
          c = s[8];
        end
        3'd2: begin cycles += 3; s[7:0] = mem_a[i] & mem_b[i]; end
        3'd3: begin cycles += 3; s[7:0] = mem_a[i] | mem_b[i]; end
        3'd4: begin cycles += 3; s[7:0] = ~mem_a[i]; end
        default: begin cycles += 3; s[7:0] = mem_a[i]; end
      endcase
      ia = i[3:0];
      exp_wr_q.push_back({ia, s[7:0]});
    end
    exp_c_q.push_back(c);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input int l,
                     input int inject_cyc, input int abort_cyc);
    int   exp_cyc, got_cyc, wr0;
    logic exp_c;
    model(o, l, exp_cyc, exp_c);
    @(posedge clk); #1;
    op = o; len = l[AW:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_cyc = 0;
    wr0 = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check({tag, "_busy"}, 32'(busy), 1);
      if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
        check({tag, "_busy_after_rst"}, 32'(busy), 0);
        rst = 1'b0;
        break;
      end
      if (abort_cyc != 0 && cyc == abort_cyc) begin
        rst = 1'b1;
        wr0 = n_writes;
      end
      if (cyc == inject_cyc) begin
        op = 3'b001; len = 1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    if (abort_cyc != 0) begin
      repeat (8) @(negedge clk);
      check({tag, "_no_wr_after_rst"}, 32'(n_writes), 32'(wr0));
      exp_wr_q.delete();
      exp_c_q.delete();
    end else begin
      check({tag, "_latency"}, 32'(got_cyc), 32'(exp_cyc));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_carry_hold"}, 32'(carry_out), 32'(exp_c));
    end
  endtask

  task automatic set_word(input int i, input logic [7:0] a, input logic [7:0] b);
    mem_a[i] = a;
    mem_b[i] = b;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) set_word(i, 8'h00, 8'h00);
    rst = 1'b1; start = 1'b0; op = 3'b000; len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_carry", 32'(carry_out), 0);
    rst = 1'b0;

    set_word(0, 8'hFF, 8'h01); set_word(1, 8'h01, 8'h00);
    run("add_a", 3'b000, 2, 0, 0);
    set_word(0, 8'hFF, 8'h01); set_word(1, 8'hFF, 8'h00);
    run("add_b", 3'b000, 2, 0, 0);
    set_word(0, 8'h00, 8'h01); set_word(1, 8'h01, 8'h00);
    run("sub_a", 3'b001, 2, 0, 0);
    run("sub_b", 3'b001, 1, 0, 0);
    set_word(0, 8'hF0, 8'h3C); set_word(1, 8'h0F, 8'h3C); set_word(2, 8'hAA, 8'hFF);
    run("and", 3'b010, 3, 0, 0);
    run("or", 3'b011, 3, 0, 0);
    set_word(0, 8'h5A, 8'h77);
    run("not", 3'b100, 1, 0, 0);
    run("mvc", 3'b101, 2, 0, 0);
    run("len0", 3'b000, 0, 0, 0);
    run("op110", 3'b110, 4, 0, 0);
    run("op111", 3'b111, 4, 0, 0);

    set_word(0, 8'hFF, 8'h01); set_word(1, 8'hFF, 8'h00);
    set_word(2, 8'h7F, 8'h80); set_word(3, 8'h12, 8'h34);
    run("add_inject", 3'b000, 4, 5, 0);
    run("add_abort", 3'b000, 4, 0, 4);
    set_word(0, 8'h01, 8'h02);
    run("add_fresh", 3'b000, 1, 0, 0);

    for (int i = 0; i < 16; i++) set_word(i, 8'($urandom), 8'($urandom));
    set_word(0, 8'hFF, 8'hFF);
    run("add_full", 3'b000, 16, 0, 0);
    run("sub_full", 3'b001, 16, 0, 0);

    check("wr_queue_empty", 32'(exp_wr_q.size()), 0);
    check("c_queue_empty", 32'(exp_c_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
